// File: rtl/mmc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmc_pkg
//  Description : Shared types and constants for the multimode counter:
//                mode enumeration, per-mode seed values and a seed lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmc_pkg;

   // Counting modes, encoded exactly as presented on the mode input
   typedef enum logic [1:0] {
      MMC_BIN  = 2'd0,
      MMC_MOD  = 2'd1,
      MMC_RING = 2'd2,
      MMC_JOHN = 2'd3
   } mmc_mode_t;

   // Value q takes on the edge where a new mode becomes active
   localparam int unsigned c_SEED_BIN  = 0;
   localparam int unsigned c_SEED_MOD  = 0;
   localparam int unsigned c_SEED_RING = 1;
   localparam int unsigned c_SEED_JOHN = 0;

   // Seed lookup; callers truncate the result to their counter width
   function automatic int unsigned mmc_seed(input mmc_mode_t m);
      int unsigned s;
      s = c_SEED_BIN;
      case (m)
         MMC_BIN  : s = c_SEED_BIN;
         MMC_MOD  : s = c_SEED_MOD;
         MMC_RING : s = c_SEED_RING;
         MMC_JOHN : s = c_SEED_JOHN;
         default  : s = c_SEED_BIN;
      endcase
      return s;
   endfunction

endpackage : mmc_pkg
`default_nettype wire

// File: rtl/mmc_next.sv
`default_nettype none
// ============================================================================
//  Module      : mmc_next
//  Description : Combinational next-state and terminal-count logic for the
//                multimode counter. Given the active mode, direction and the
//                current count it produces the value of one counted step and
//                the terminal flag for that mode/direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module mmc_next
   import mmc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  mmc_mode_t        mode,
   input  logic             up,
   input  logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] nxt,
   output logic             tc
);

   localparam logic [WIDTH-1:0] c_ZERO    = '0;
   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] c_ALL1    = '1;
   localparam logic [WIDTH-1:0] c_MSB     = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] c_MOD_MAX = WIDTH'(MOD - 1);

   // One counted step and the terminal test, selected by mode and direction
   always_comb begin
      nxt = q;
      tc  = 1'b0;
      case (mode)
         MMC_BIN : begin
            if (up) begin
               nxt = q + c_ONE;
               tc  = (q == c_ALL1);
            end else begin
               nxt = q - c_ONE;
               tc  = (q == c_ZERO);
            end
         end
         MMC_MOD : begin
            if (up) begin
               nxt = (q == c_MOD_MAX) ? c_ZERO : q + c_ONE;
               tc  = (q == c_MOD_MAX);
            end else begin
               nxt = (q == c_ZERO) ? c_MOD_MAX : q - c_ONE;
               tc  = (q == c_ZERO);
            end
         end
         MMC_RING : begin
            if (up) begin
               nxt = {q[WIDTH-2:0], q[WIDTH-1]};
               tc  = (q == c_MSB);
            end else begin
               nxt = {q[0], q[WIDTH-1:1]};
               tc  = (q == c_ONE);
            end
         end
         MMC_JOHN : begin
            if (up) begin
               nxt = {q[WIDTH-2:0], ~q[WIDTH-1]};
               tc  = (q == c_MSB);
            end else begin
               nxt = {~q[0], q[WIDTH-1:1]};
               tc  = (q == c_ONE);
            end
         end
         default : begin
            nxt = q;
            tc  = 1'b0;
         end
      endcase
   end

endmodule : mmc_next
`default_nettype wire

// File: rtl/multimode_counter.sv
`default_nettype none
// ============================================================================
//  Module      : multimode_counter
//  Description : WIDTH-bit counter with binary, modulo-MOD, ring and johnson
//                modes. Per edge: mode change (reseed) > load > count > hold.
//                tc flags the terminal value of the active mode/direction;
//                wrap pulses for one cycle after a counted step out of it.
//                Optional macro MMC_DOWN_EN enables the up input; without it
//                every mode counts up only.
//  Revision    : 1.0 - initial release
// ============================================================================
module multimode_counter
   import mmc_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int MOD   = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);
   localparam logic [WIDTH:0]   c_MOD_EXT = (WIDTH+1)'(MOD);

   logic [WIDTH-1:0] r_q;
   logic             r_wrap;
   mmc_mode_t        r_mode_q;

   mmc_mode_t        w_mode;
   logic             w_mode_chg;
   logic             w_dir_up;
   logic [WIDTH-1:0] w_step;
   logic             w_tc;
   logic [WIDTH-1:0] w_seed;
   logic             w_in_range;
   logic             w_onehot;
   logic [WIDTH-1:0] w_load_q;
   logic [WIDTH-1:0] w_q_nxt;
   mmc_mode_t        w_mode_nxt;
   logic             w_wrap_nxt;

   assign w_mode     = mmc_mode_t'(mode);
   assign w_mode_chg = (w_mode != r_mode_q);

`ifdef MMC_DOWN_EN
   assign w_dir_up = up;
`else
   // Direction is fixed to up; up is kept only as an intentionally unused tap
   logic w_unused_up;
   assign w_unused_up = up;
   assign w_dir_up    = 1'b1;
`endif

   mmc_next #(
      .WIDTH (WIDTH),
      .MOD   (MOD)
   ) u_next (
      .mode (r_mode_q),
      .up   (w_dir_up),
      .q    (r_q),
      .nxt  (w_step),
      .tc   (w_tc)
   );

   assign w_seed     = WIDTH'(mmc_seed(w_mode));
   assign w_in_range = ({1'b0, load_val} < c_MOD_EXT);
   assign w_onehot   = (load_val != '0) && ((load_val & (load_val - c_ONE)) == '0);

   // Sanitise the load value so q never leaves the legal set of the active mode
   always_comb begin
      w_load_q = load_val;
      case (r_mode_q)
         MMC_BIN  : w_load_q = load_val;
         MMC_MOD  : w_load_q = w_in_range ? load_val : '0;
         MMC_RING : w_load_q = w_onehot ? load_val : WIDTH'(c_SEED_RING);
         MMC_JOHN : w_load_q = r_q;
         default  : w_load_q = load_val;
      endcase
   end

   // Edge priority: mode change, then load, then count, else hold
   always_comb begin
      w_q_nxt    = r_q;
      w_mode_nxt = r_mode_q;
      w_wrap_nxt = 1'b0;
      if (w_mode_chg) begin
         w_q_nxt    = w_seed;
         w_mode_nxt = w_mode;
      end else if (load) begin
         w_q_nxt    = w_load_q;
      end else if (en) begin
         w_q_nxt    = w_step;
         w_wrap_nxt = w_tc;
      end
   end

   // State registers; reset clears count, wrap and returns to binary mode at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q      <= '0;
         r_wrap   <= 1'b0;
         r_mode_q <= MMC_BIN;
      end else begin
         r_q      <= w_q_nxt;
         r_wrap   <= w_wrap_nxt;
         r_mode_q <= w_mode_nxt;
      end
   end

   assign q    = r_q;
   assign wrap = r_wrap;
   assign tc   = w_tc;

endmodule : multimode_counter
`default_nettype wire

// File: doc/multimode_counter.md
MULTIMODE_COUNTER -- requirements
Module: multimode_counter

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set counter width in bits (legal 2..32).
REQ-002 Parameter MOD, default 10, SHALL set the modulo-mode period (legal 2..2**WIDTH).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 en  input  1  SHALL enable counting when high.
REQ-006 mode  input  2  SHALL select the mode: 0 binary, 1 modulo-MOD, 2 ring, 3 johnson.
REQ-007 up  input  1  SHALL set the direction: 1 up/left, 0 down/right (used only with MMC_DOWN_EN).
REQ-008 load  input  1  SHALL request a synchronous load of load_val.
REQ-009 load_val  input  WIDTH  SHALL be the value to load.
REQ-010 q  output  WIDTH  SHALL be the registered counter state.
REQ-011 tc  output  1  SHALL flag the terminal count for the current mode and direction.
REQ-012 wrap  output  1  SHALL be a registered one-cycle pulse after each counted step out of a terminal state.

Function
REQ-013 Per-edge priority SHALL be: mode change > load > count (en) > hold.
REQ-014 Internal mode_q SHALL register the active mode; when mode != mode_q at an edge, q SHALL take the seed of the new mode (binary 0, modulo 0, ring 1, johnson 0), mode_q SHALL update, and en/load SHALL be ignored that cycle.
REQ-015 Binary mode SHALL step q +1 (up) or -1 (down) mod 2**WIDTH.
REQ-016 Modulo mode up SHALL step 0..MOD-1 then return to 0; down SHALL step from 0 to MOD-1.
REQ-017 Ring mode up SHALL rotate q left one bit; down SHALL rotate q right one bit.
REQ-018 Johnson mode up SHALL shift left with ~q[WIDTH-1] into bit 0; down SHALL shift right with ~q[0] into bit WIDTH-1.
REQ-019 Load in binary mode SHALL load load_val unchanged.
REQ-020 Load in modulo mode SHALL load load_val if it is below MOD, else 0.
REQ-021 Load in ring mode SHALL load load_val if it is one-hot, else the seed 1.
REQ-022 Load in johnson mode SHALL be ignored.
REQ-023 tc SHALL be combinational and independent of en; it is asserted when q equals the terminal value below.
REQ-024 Terminal values SHALL be: binary up all-ones, down 0; modulo up MOD-1, down 0; ring up MSB-only, down 1; johnson up MSB-only, down 1.
REQ-025 wrap SHALL be set at an edge where en=1, no load, no mode change, and tc=1; otherwise it SHALL be cleared.
REQ-026 A direction change SHALL take effect on the next counted edge, with no reseed.

Reset
REQ-027 When reset is low, q, wrap and mode_q (binary) SHALL be 0 immediately, regardless of clk.
REQ-028 After reset deasserts with mode=ring, the first edge SHALL seed q to 1 through the mode-change rule.
REQ-029 Reset asserted mid-count SHALL abort the count; no wrap pulse SHALL follow.

Configuration
REQ-030 With macro MMC_DOWN_EN defined, the up input SHALL control direction as specified above.
REQ-031 Without MMC_DOWN_EN, up SHALL be ignored and all modes SHALL count up only; tc SHALL use the up-terminal values.

Structure
REQ-032 Package mmc_pkg SHALL hold the mode enumeration (MMC_BIN, MMC_MOD, MMC_RING, MMC_JOHN) and the per-mode seed constants.
REQ-033 Sub-module mmc_next SHALL compute the next state and terminal flag combinationally; the top SHALL hold the registers, priority and load-sanitising logic.

Verification (WIDTH=4, MOD=10, MMC_DOWN_EN defined)
REQ-034 Modulo up, en=1 for 12 edges from 0 -> q steps 0..9, 0, 1; tc high at q=9; wrap pulses once, the cycle after 9->0.
REQ-035 Ring up for 5 edges after reset -> q = 0001 (seed), 0010, 0100, 1000, 0001.
REQ-036 Johnson up for 9 edges from 0 -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; tc at 1000.
REQ-037 Binary down from 0, then load 1010 with en=1 -> q goes 0 to 1111 with wrap; load wins and q=1010.
REQ-038 Modulo load 1100 -> q=0; ring load 0110 -> q=0001; switching mode from binary (q=0111) to ring -> q=0001 on that edge with en ignored.
REQ-039 Async reset pulse between edges during binary up at q=0101 -> q=0 before the next edge; wrap=0.
